// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator with a time-multiplexed slot scanner.
// Note events update the voice table; each sample tick walks every voice once, one slot per clock.
module voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3,
  parameter int AGE_W      = 4
) (
  input  logic                  inCLK,
  input  logic                  inRESET_N,
  input  logic                  inNoteValid,
  input  logic                  inNoteOn,
  input  logic [6:0]            inNoteIndex,
  input  logic [6:0]            inNoteVelocity,
  input  logic                  inSampleClockCE,
  output logic                  outSlotValid,
  output logic [VOICE_W-1:0]    outVoiceIndex,
  output logic [6:0]            outFrequencyIndex,
  output logic [6:0]            outVelocity,
  output logic                  outVoiceActive,
  output logic                  outFrameDone,
  output logic [NUM_VOICES-1:0] outActiveMask,
  output logic                  outSteal,
  output logic                  outOverrun
);

  localparam logic [0:0]         IDLE      = 1'b0;
  localparam logic [0:0]         SCAN      = 1'b1;
  localparam logic [VOICE_W-1:0] LAST_SLOT = VOICE_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]   AGE_MAX   = '1;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [6:0]            vel_d  [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];

  logic                  is_on, is_off;
  logic [NUM_VOICES-1:0] hit_vec;
  logic                  hit_found, free_found;
  logic [VOICE_W-1:0]    hit_idx, free_idx, old_idx, target_idx;
  logic [AGE_W-1:0]      old_age;
  logic                  steal_q, steal_d;
  logic [NUM_VOICES-1:0] mask_q;

  logic [0:0]            state_q, state_d;
  logic [VOICE_W-1:0]    slot_q, slot_d;
  logic                  valid_q, valid_d;
  logic [VOICE_W-1:0]    vidx_q, vidx_d;
  logic [6:0]            freq_q, freq_d;
  logic [6:0]            svel_q, svel_d;
  logic                  vact_q, vact_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  // Allocation: retrigger a sounding match, else lowest free voice, else oldest voice (lowest index on ties).
  always_comb begin
    active_d   = active_q;
    note_d     = note_q;
    vel_d      = vel_q;
    age_d      = age_q;
    steal_d    = 1'b0;
    is_on      = inNoteValid && inNoteOn && (inNoteVelocity != 7'd0);
    is_off     = inNoteValid && !is_on;
    hit_vec    = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit_vec[v] = active_q[v] && (note_q[v] == inNoteIndex);
      if (hit_vec[v] && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = VOICE_W'(v);
      end
      if (!active_q[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VOICE_W'(v);
      end
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = VOICE_W'(v);
      end
    end
    target_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    if (is_on) begin
      steal_d = !hit_found && !free_found;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VOICE_W'(v) == target_idx) begin
          active_d[v] = 1'b1;
          note_d[v]   = inNoteIndex;
          vel_d[v]    = inNoteVelocity;
          age_d[v]    = '0;
        end else if (active_q[v] && (age_q[v] != AGE_MAX)) begin
          age_d[v] = age_q[v] + AGE_W'(1);
        end
      end
    end else if (is_off) begin
      active_d = active_q & ~hit_vec;
    end
  end

  always_ff @(posedge inCLK or negedge inRESET_N) begin
    if (!inRESET_N) begin
      active_q <= '0;
      steal_q  <= 1'b0;
      mask_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
      steal_q  <= steal_d;
      mask_q   <= active_q;
    end
  end

  // Slot registers load from the current table, so a slot shows the table as of the previous cycle.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    vidx_d    = '0;
    freq_d    = '0;
    svel_d    = '0;
    vact_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (inSampleClockCE) begin
          state_d = SCAN;
          slot_d  = '0;
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        overrun_d = inSampleClockCE;
        if (slot_q == LAST_SLOT) begin
          state_d = IDLE;
        end else begin
          slot_d  = slot_q + VOICE_W'(1);
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (valid_d) begin
      vidx_d = slot_d;
      freq_d = note_q[slot_d];
      svel_d = vel_q[slot_d];
      vact_d = active_q[slot_d];
      done_d = (slot_d == LAST_SLOT);
    end
  end

  always_ff @(posedge inCLK or negedge inRESET_N) begin
    if (!inRESET_N) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      valid_q   <= 1'b0;
      vidx_q    <= '0;
      freq_q    <= '0;
      svel_q    <= '0;
      vact_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      vidx_q    <= vidx_d;
      freq_q    <= freq_d;
      svel_q    <= svel_d;
      vact_q    <= vact_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign outSlotValid      = valid_q;
  assign outVoiceIndex     = vidx_q;
  assign outFrequencyIndex = freq_q;
  assign outVelocity       = svel_q;
  assign outVoiceActive    = vact_q;
  assign outFrameDone      = done_q;
  assign outActiveMask     = mask_q;
  assign outSteal          = steal_q;
  assign outOverrun        = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a reference voice table predicts every slot of every frame,
// plus steal pulses, the active mask, overrun and reset behaviour.
module tb_voice_scheduler;

  localparam int NV = 8;
  localparam int VW = 3;
  localparam int AW = 4;

  logic          inCLK = 1'b0;
  logic          inRESET_N = 1'b0;
  logic          inNoteValid = 1'b0;
  logic          inNoteOn = 1'b0;
  logic [6:0]    inNoteIndex = '0;
  logic [6:0]    inNoteVelocity = '0;
  logic          inSampleClockCE = 1'b0;
  logic          outSlotValid;
  logic [VW-1:0] outVoiceIndex;
  logic [6:0]    outFrequencyIndex;
  logic [6:0]    outVelocity;
  logic          outVoiceActive;
  logic          outFrameDone;
  logic [NV-1:0] outActiveMask;
  logic          outSteal;
  logic          outOverrun;

  voice_scheduler #(.NUM_VOICES(NV), .VOICE_W(VW), .AGE_W(AW)) dut (
    .inCLK(inCLK), .inRESET_N(inRESET_N),
    .inNoteValid(inNoteValid), .inNoteOn(inNoteOn),
    .inNoteIndex(inNoteIndex), .inNoteVelocity(inNoteVelocity),
    .inSampleClockCE(inSampleClockCE),
    .outSlotValid(outSlotValid), .outVoiceIndex(outVoiceIndex),
    .outFrequencyIndex(outFrequencyIndex), .outVelocity(outVelocity),
    .outVoiceActive(outVoiceActive), .outFrameDone(outFrameDone),
    .outActiveMask(outActiveMask), .outSteal(outSteal), .outOverrun(outOverrun)
  );

  always #5 inCLK = ~inCLK;

  typedef struct packed {
    logic [VW-1:0] idx;
    logic [6:0]    freq;
    logic [6:0]    vel;
    logic          act;
    logic          done;
  } slot_t;

  slot_t         exp_q[$];
  int            check_count = 0;
  int            error_count = 0;
  logic          m_active [NV];
  logic [6:0]    m_note   [NV];
  logic [6:0]    m_vel    [NV];
  logic [AW-1:0] m_age    [NV];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every slot the DUT emits is popped from the scoreboard; idle cycles must keep slot outputs at zero.
  always @(negedge inCLK) begin
    slot_t want;
    if (inRESET_N) begin
      if (outSlotValid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_slot", 32'(outVoiceIndex) | 32'h100, 32'h0);
        end else begin
          want = exp_q.pop_front();
          checkOutput("slot_index",  32'(outVoiceIndex),     32'(want.idx));
          checkOutput("slot_freq",   32'(outFrequencyIndex), 32'(want.freq));
          checkOutput("slot_vel",    32'(outVelocity),       32'(want.vel));
          checkOutput("slot_active", 32'(outVoiceActive),    32'(want.act));
          checkOutput("frame_done",  32'(outFrameDone),      32'(want.done));
        end
      end else begin
        checkOutput("idle_outputs",
          32'({outVoiceIndex, outFrequencyIndex, outVelocity, outVoiceActive, outFrameDone}), 32'h0);
      end
    end
  end

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_active[v] = 1'b0;
      m_note[v]   = '0;
      m_vel[v]    = '0;
      m_age[v]    = '0;
    end
  endtask

  function automatic logic [NV-1:0] model_mask();
    logic [NV-1:0] m;
    for (int v = 0; v < NV; v++) m[v] = m_active[v];
    return m;
  endfunction

  task automatic model_note(input logic on, input logic [6:0] note, input logic [6:0] vel, output logic steal);
    int hit, free, tgt;
    hit = -1;
    free = -1;
    tgt = 0;
    steal = 1'b0;
    if (on && vel != 7'd0) begin
      for (int v = 0; v < NV; v++) begin
        if (hit < 0 && m_active[v] && m_note[v] == note) hit = v;
        if (free < 0 && !m_active[v]) free = v;
      end
      if (hit >= 0) tgt = hit;
      else if (free >= 0) tgt = free;
      else begin
        steal = 1'b1;
        for (int v = 1; v < NV; v++) if (m_age[v] > m_age[tgt]) tgt = v;
      end
      for (int v = 0; v < NV; v++) begin
        if (v == tgt) begin
          m_active[v] = 1'b1;
          m_note[v]   = note;
          m_vel[v]    = vel;
          m_age[v]    = '0;
        end else if (m_active[v] && m_age[v] != 4'hF) begin
          m_age[v] = m_age[v] + 4'd1;
        end
      end
    end else begin
      for (int v = 0; v < NV; v++) if (m_active[v] && m_note[v] == note) m_active[v] = 1'b0;
    end
  endtask

  task automatic push_slots(input int first, input int last);
    slot_t s;
    for (int v = first; v <= last; v++) begin
      s.idx  = VW'(v);
      s.freq = m_note[v];
      s.vel  = m_vel[v];
      s.act  = m_active[v];
      s.done = (v == NV - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic applyStimulus(input logic on, input logic [6:0] note, input logic [6:0] vel);
    logic exp_steal;
    model_note(on, note, vel, exp_steal);
    inNoteValid = 1'b1;
    inNoteOn = on;
    inNoteIndex = note;
    inNoteVelocity = vel;
    @(posedge inCLK);
    #1;
    inNoteValid = 1'b0;
    inNoteOn = 1'b0;
    inNoteIndex = '0;
    inNoteVelocity = '0;
    @(negedge inCLK);
    checkOutput("steal", 32'(outSteal), 32'(exp_steal));
  endtask

  task automatic applyTick();
    push_slots(0, NV - 1);
    inSampleClockCE = 1'b1;
    @(posedge inCLK);
    #1;
    inSampleClockCE = 1'b0;
  endtask

  task automatic waitFrame();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge inCLK);
      n++;
    end
    checkOutput("frame_drain", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    @(posedge inCLK);
    #1;
  endtask

  task automatic checkMask(input string tag);
    repeat (2) @(posedge inCLK);
    @(negedge inCLK);
    checkOutput(tag, 32'(outActiveMask), 32'(model_mask()));
  endtask

  task automatic tickFrame();
    applyTick();
    waitFrame();
  endtask

  // Note event and tick share a cycle: slot 0 sees the old table, later slots the updated one.
  task automatic applyNoteTick(input logic [6:0] note, input logic [6:0] vel);
    logic exp_steal;
    push_slots(0, 0);
    model_note(1'b1, note, vel, exp_steal);
    push_slots(1, NV - 1);
    inNoteValid = 1'b1;
    inNoteOn = 1'b1;
    inNoteIndex = note;
    inNoteVelocity = vel;
    inSampleClockCE = 1'b1;
    @(posedge inCLK);
    #1;
    inNoteValid = 1'b0;
    inSampleClockCE = 1'b0;
    @(negedge inCLK);
    checkOutput("steal_with_tick", 32'(outSteal), 32'(exp_steal));
    waitFrame();
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge inCLK);
    #1;
    checkOutput("reset_valid", 32'(outSlotValid), 32'h0);
    checkOutput("reset_mask", 32'(outActiveMask), 32'h0);
    checkOutput("reset_pulses", 32'({outSteal, outOverrun, outFrameDone}), 32'h0);
    inRESET_N = 1'b1;
    @(posedge inCLK);
    #1;

    tickFrame();

    applyStimulus(1'b1, 7'd60, 7'd100);
    applyStimulus(1'b1, 7'd64, 7'd80);
    applyStimulus(1'b1, 7'd67, 7'd90);
    checkMask("mask_three");
    tickFrame();

    applyStimulus(1'b0, 7'd60, 7'd0);
    applyStimulus(1'b0, 7'd64, 7'd0);
    applyStimulus(1'b0, 7'd67, 7'd0);
    for (int n = 60; n < 68; n++) applyStimulus(1'b1, 7'(n), 7'(n - 40));
    checkMask("mask_filled");
    applyStimulus(1'b1, 7'd70, 7'd50);
    checkMask("mask_after_steal");
    tickFrame();

    applyStimulus(1'b0, 7'd62, 7'd0);
    checkMask("mask_off62");
    applyStimulus(1'b1, 7'd72, 7'd10);
    applyStimulus(1'b0, 7'd99, 7'd0);
    checkMask("mask_off99");
    tickFrame();

    applyStimulus(1'b0, 7'd70, 7'd0);
    applyStimulus(1'b1, 7'd60, 7'd100);
    applyStimulus(1'b1, 7'd60, 7'd0);
    checkMask("mask_vel0_off");
    applyStimulus(1'b1, 7'd60, 7'd30);
    applyStimulus(1'b1, 7'd60, 7'd30);
    checkMask("mask_retrigger");
    tickFrame();

    for (int i = 0; i < 30; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                    7'(60 + $urandom_range(0, 9)),
                    ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127)));
      if (i % 6 == 5) begin
        checkMask("mask_random");
        tickFrame();
      end
    end

    // Repeated retriggers drive other voices' ages into saturation, then steals resolve ties.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 7'd61, 7'd5);
    for (int n = 80; n < 90; n++) applyStimulus(1'b1, 7'(n), 7'(n - 70));
    checkMask("mask_saturate");
    tickFrame();

    applyNoteTick(7'd90, 7'd77);

    applyTick();
    repeat (2) @(posedge inCLK);
    #1;
    inSampleClockCE = 1'b1;
    @(posedge inCLK);
    #1;
    inSampleClockCE = 1'b0;
    @(negedge inCLK);
    checkOutput("overrun", 32'(outOverrun), 32'h1);
    waitFrame();

    applyTick();
    repeat (2) @(posedge inCLK);
    #2;
    inRESET_N = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    checkOutput("midscan_reset_outputs",
      32'({outSlotValid, outVoiceIndex, outFrequencyIndex, outVelocity, outVoiceActive, outFrameDone}), 32'h0);
    checkOutput("midscan_reset_mask", 32'(outActiveMask), 32'h0);
    repeat (2) @(posedge inCLK);
    #1;
    inRESET_N = 1'b1;
    repeat (12) @(posedge inCLK);
    #1;
    tickFrame();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
